demux_chan_fifo: RTL

//   Four-channel capture/buffer stage directly downstream of demux_1to4. Takes the four demux

---
 rtl/demux_chan_fifo.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/demux_chan_fifo.sv
// -----------------------------------------------------------------------------
// demux_chan_fifo
//   Four-channel capture/buffer stage that sits directly after demux_1to4.
//   The word on out<sel> is pushed into FIFO[sel] when in_valid is high and that
//   FIFO has room. Each channel is then exposed to its own consumer as an
//   independent first-word-fall-through valid/ready stream.
//
// Parameters
//   WIDTH  data width (matches demux_1to4)
//   DEPTH  entries per channel FIFO, power of 2, >= 2
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       word on out<sel> is valid this cycle
//   sel[1:0]       target channel (same select as the demux)
//   out0..out3     demux outputs; only out<sel> is sampled
//   in_ready       selected channel FIFO not full
//   ch_valid[3:0]  channel n FIFO non-empty
//   ch_ready[3:0]  consumer n accepts its head word
//   ch0..ch3_data  head word of each channel (0 while the channel is empty)
//   ch_full[3:0]   channel n FIFO holds DEPTH words
//   ovf_sticky[3:0] a word for channel n was dropped since reset
//   drop_cnt[31:0] per-channel saturating drop counters, channel n at [8n+7:8n]
//                  (only when DEMUX_DROP_CNT_EN is defined)
//
// Build option
//   DEMUX_DROP_CNT_EN  adds the drop_cnt output and its counters.
// -----------------------------------------------------------------------------
module demux_chan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] out0,
  input  logic [WIDTH-1:0] out1,
  input  logic [WIDTH-1:0] out2,
  input  logic [WIDTH-1:0] out3,
  output logic             in_ready,
  output logic [3:0]       ch_valid,
  input  logic [3:0]       ch_ready,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic [WIDTH-1:0] ch2_data,
  output logic [WIDTH-1:0] ch3_data,
  output logic [3:0]       ch_full,
  output logic [3:0]       ovf_sticky
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [31:0]      drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Storage is deliberately not reset; empty channels mask their head word.
  logic [WIDTH-1:0] mem [4][DEPTH];
  logic [AW-1:0]    wr_ptr [4];
  logic [AW-1:0]    rd_ptr [4];
  logic [AW:0]      count  [4];
  logic [WIDTH-1:0] head   [4];
  logic [WIDTH-1:0] sel_data;
  logic             push;
  logic [3:0]       push_ch;
  logic [3:0]       pop_ch;
  logic [3:0]       drop_ch;

  always_comb begin
    sel_data = out0;
    case (sel)
      2'd0: sel_data = out0;
      2'd1: sel_data = out1;
      2'd2: sel_data = out2;
      2'd3: sel_data = out3;
      default: sel_data = out0;
    endcase
  end

  // Channel status is derived purely from the occupancy count.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      ch_valid[n] = (count[n] != '0);
      ch_full[n]  = (count[n] == FULL_CNT);
      head[n]     = ch_valid[n] ? mem[n][rd_ptr[n]] : '0;
    end
  end

  // in_ready ignores a same-cycle pop: a full channel never accepts a word,
  // even if its consumer is draining it on the same edge.
  assign in_ready = ~ch_full[sel];
  assign push     = in_valid & in_ready;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      push_ch[n] = push && (sel == 2'(n));
      drop_ch[n] = in_valid && !in_ready && (sel == 2'(n));
      pop_ch[n]  = ch_valid[n] && ch_ready[n];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[sel][wr_ptr[sel]] <= sel_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
      end
      ovf_sticky <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push_ch[n]) begin
          wr_ptr[n] <= wr_ptr[n] + 1'b1;
        end
        if (pop_ch[n]) begin
          rd_ptr[n] <= rd_ptr[n] + 1'b1;
        end
        case ({push_ch[n], pop_ch[n]})
          2'b10:   count[n] <= count[n] + 1'b1;
          2'b01:   count[n] <= count[n] - 1'b1;
          default: count[n] <= count[n];
        endcase
        if (drop_ch[n]) begin
          ovf_sticky[n] <= 1'b1;
        end
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        drop_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (drop_ch[n] && (drop_q[n] != 8'hFF)) begin
          drop_q[n] <= drop_q[n] + 8'd1;
        end
      end
    end
  end

  assign drop_cnt = {drop_q[3], drop_q[2], drop_q[1], drop_q[0]};
`endif

  assign ch0_data = head[0];
  assign ch1_data = head[1];
  assign ch2_data = head[2];
  assign ch3_data = head[3];

endmodule
